// File: rtl/mux_8_2_1_sched_pkg.sv
// Shared constants, state encoding and helpers for the scheduled 8:1 bit mux.
package mux_8_2_1_sched_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_8_2_1.sv
// Plain combinational 8:1 single-bit multiplexer.
module mux_8_2_1 (
    input  logic [2:0] sel,
    input  logic [7:0] in,
    output logic       out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_8_2_1_sched.sv
// Round-robin scheduler in front of an 8:1 bit mux; each grant lasts up to
// HOLD_MAX accepted beats or until the granted requester drops its request.
module mux_8_2_1_sched
    import mux_8_2_1_sched_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] din,
    input  logic       out_ready,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       out_valid,
    output logic       out_bit
);

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;

    logic [N_REQ-1:0]   rot_req;
    logic [SEL_W-1:0]   rr_off;
    logic [SEL_W-1:0]   winner;
    logic               beat;
    logic               hold_done;
    logic               release_grant;

    // rot_req[k] is the request of index sel+1+k, so the current sel lands last.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot_req[gi] = req[sel_reg + SEL_W'(gi + 1)];
        end
    endgenerate

    always_comb begin
        rr_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                rr_off = SEL_W'(i);
            end
        end
    end

    assign winner        = sel_reg + rr_off + SEL_W'(1);
    assign beat          = out_valid && out_ready;
    assign hold_done     = beat && (beat_cnt_reg + CNT_W'(1) == CNT_W'(HOLD_MAX));
    assign release_grant = !req[sel_reg] || hold_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            sel_reg      <= '1;
            grant_reg    <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            grant_reg    <= grant_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next    = GRANT;
                    sel_next      = winner;
                    beat_cnt_next = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    beat_cnt_next = '0;
                    if (|req) begin
                        sel_next = winner;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (beat) begin
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        grant_next = (state_next == GRANT) ? onehot(sel_next) : '0;
    end

    always_comb begin
        out_valid = (state_reg == GRANT) && req[sel_reg];
    end

    assign sel   = sel_reg;
    assign grant = grant_reg;

    mux_8_2_1 u_mux (
        .sel (sel_reg),
        .in  (din),
        .out (out_bit)
    );

endmodule

// File: tb/tb_mux_8_2_1_sched.sv
// Directed vector bench for mux_8_2_1_sched: each vector drives one cycle of
// inputs and checks the outputs mid-cycle, before that cycle's rising edge.
module tb_mux_8_2_1_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] din;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       out_valid;
    logic       out_bit;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] din;
        logic       rdy;
        logic [2:0] sel;
        logic [7:0] grant;
        logic       valid;
        logic       ob;
    } vec_t;

    vec_t vecs[$];

    mux_8_2_1_sched #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .out_bit   (out_bit)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [7:0] q, input logic [7:0] d,
                       input logic y, input logic [2:0] s, input logic [7:0] g,
                       input logic v, input logic b);
        vec_t t;
        t = '{rst: r, req: q, din: d, rdy: y, sel: s, grant: g, valid: v, ob: b};
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle just after the rising edge, compare at the falling edge.
    task automatic step(input vec_t t, input int idx);
        rst       = t.rst;
        req       = t.req;
        din       = t.din;
        out_ready = t.rdy;
        @(negedge clk);
        check("sel", idx, {5'b0, sel}, {5'b0, t.sel});
        check("grant", idx, grant, t.grant);
        check("out_valid", idx, {7'b0, out_valid}, {7'b0, t.valid});
        check("out_bit", idx, {7'b0, out_bit}, {7'b0, t.ob});
        $display("vec=%0d rst=%b req=%h din=%h rdy=%b -> sel=%0d grant=%h valid=%b bit=%b",
                 idx, t.rst, t.req, t.din, t.rdy, sel, grant, out_valid, out_bit);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t t;
        rst = 1'b1; req = '0; din = 8'hA5; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then a single requester held for HOLD_MAX and regranted
        add(1, 8'h00, 8'hA5, 1, 3'd7, 8'h00, 0, 1);
        add(0, 8'h01, 8'hA5, 1, 3'd7, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 8'h01, 8'hA5, 1, 3'd0, 8'h01, 1, 1);
        add(0, 8'h00, 8'hA5, 1, 3'd0, 8'h01, 0, 1);
        add(0, 8'h00, 8'hA5, 1, 3'd0, 8'h00, 0, 1);
        // Two requesters alternate every four beats with no idle gap
        add(0, 8'h84, 8'hA5, 1, 3'd0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 8'h84, 8'hA5, 1, 3'd2, 8'h04, 1, 1);
        for (int i = 0; i < 4; i++) add(0, 8'h84, 8'hA5, 1, 3'd7, 8'h80, 1, 1);
        // Granted requester drops after one beat
        add(0, 8'h0C, 8'hA5, 1, 3'd2, 8'h04, 1, 1);
        add(0, 8'h08, 8'hA5, 1, 3'd2, 8'h04, 0, 1);
        add(0, 8'h08, 8'hA5, 1, 3'd3, 8'h08, 1, 0);
        // Ten stalled cycles must not consume beats
        add(0, 8'h10, 8'hA5, 0, 3'd3, 8'h08, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 8'h10, 8'hA5, 0, 3'd4, 8'h10, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 8'h10, 8'hA5, 1, 3'd4, 8'h10, 1, 0);
        add(0, 8'h30, 8'hA5, 1, 3'd4, 8'h10, 1, 0);
        // Reset during beat 2 of a grant to index 5
        add(0, 8'h20, 8'hA5, 1, 3'd5, 8'h20, 1, 1);
        add(1, 8'h20, 8'hA5, 1, 3'd5, 8'h20, 1, 1);
        add(0, 8'h20, 8'hA5, 1, 3'd7, 8'h00, 0, 1);
        add(0, 8'h20, 8'hA5, 1, 3'd5, 8'h20, 1, 1);
        // Walk the grant across every index to read din = A5 through the mux
        add(0, 8'h40, 8'hA5, 1, 3'd5, 8'h20, 0, 1);
        add(0, 8'h80, 8'hA5, 1, 3'd6, 8'h40, 0, 0);
        add(0, 8'h01, 8'hA5, 1, 3'd7, 8'h80, 0, 1);
        add(0, 8'h02, 8'hA5, 1, 3'd0, 8'h01, 0, 1);
        add(0, 8'h04, 8'hA5, 1, 3'd1, 8'h02, 0, 0);
        add(0, 8'h08, 8'hA5, 1, 3'd2, 8'h04, 0, 1);
        add(0, 8'h10, 8'hA5, 1, 3'd3, 8'h08, 0, 0);
        add(0, 8'h20, 8'hA5, 1, 3'd4, 8'h10, 0, 0);
        add(0, 8'h00, 8'hA5, 1, 3'd5, 8'h20, 0, 1);
        add(0, 8'h00, 8'hA5, 1, 3'd5, 8'h00, 0, 1);
        add(0, 8'h00, 8'h5A, 1, 3'd5, 8'h00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // Reset wins over a full request vector on the same edge
        t = '{rst: 1, req: 8'hFF, din: 8'h5A, rdy: 1, sel: 3'd5, grant: 8'h00, valid: 0, ob: 0};
        step(t, 100);
        t = '{rst: 0, req: 8'h00, din: 8'h5A, rdy: 1, sel: 3'd7, grant: 8'h00, valid: 0, ob: 0};
        step(t, 101);
        t = '{rst: 0, req: 8'hFF, din: 8'h5A, rdy: 1, sel: 3'd7, grant: 8'h00, valid: 0, ob: 0};
        step(t, 102);
        t = '{rst: 0, req: 8'hFF, din: 8'h5A, rdy: 1, sel: 3'd0, grant: 8'h01, valid: 1, ob: 0};
        step(t, 103);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_8_2_1_sched.md
MUX_8_2_1_SCHED -- requirements
Module: mux_8_2_1_sched

Interface
REQ-001: Parameter HOLD_MAX, default 4, SHALL set the maximum beats per grant (legal range 1..15).
REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004: req  input  8  SHALL carry the per-requester request lines; bit i is requester i.
REQ-005: din  input  8  SHALL carry the per-requester data bits; bit i is requester i's data.
REQ-006: out_ready  input  1  SHALL be the consumer ready; a beat occurs when out_valid && out_ready.
REQ-007: sel  output  3  SHALL be the registered index of the granted requester.
REQ-008: grant  output  8  SHALL be registered one-hot grant, or all-zero when idle.
REQ-009: out_valid  output  1  SHALL be high iff state is GRANT and req[sel] is high (combinational on req).
REQ-010: out_bit  output  1  SHALL equal din[sel] (combinational).

Function
REQ-011: The FSM SHALL have two states, IDLE and GRANT.
REQ-012: In IDLE with req != 0, the next cycle SHALL enter GRANT with the round-robin winner; req-to-grant latency is 1 cycle.
REQ-013: In IDLE with req == 0, it SHALL stay in IDLE; grant SHALL be 0 and out_valid SHALL be 0.
REQ-014: Round-robin search SHALL start at (sel+1) mod 8 and wrap upward; the current sel SHALL be checked last.
REQ-015: In GRANT, beat_cnt (4-bit, internal) SHALL increment on each beat and be cleared on every new grant.
REQ-016: A grant SHALL be released on the cycle where a beat brings beat_cnt to HOLD_MAX, or on any cycle where req[sel] is low.
REQ-017: On release, if any req bit (sampled that cycle, the releasing requester included) is high, the next cycle SHALL be GRANT to the new winner, with no idle gap.
REQ-018: On release with no req bit high, the next cycle SHALL be IDLE, with grant = 0 and sel holding its last value.
REQ-019: A sole remaining requester reaching HOLD_MAX SHALL be regranted next cycle with beat_cnt = 0.
REQ-020: out_ready low SHALL stall beat_cnt; there is no timeout.
REQ-021: grant SHALL always equal one-hot(sel) in GRANT.

Reset
REQ-022: rst SHALL override all other inputs on the same edge.
REQ-023: After reset: state = IDLE, sel = 3'b111 (first search starts at 0), grant = 8'h00, beat_cnt = 0, out_valid = 0.
REQ-024: Reset asserted mid-grant SHALL drop grant and out_valid on the next edge, and no beat SHALL be counted in that cycle.

Structure
REQ-025: Package mux_8_2_1_sched_pkg SHALL hold N_REQ = 8, SEL_W = 3, CNT_W = 4, and the state enum {IDLE, GRANT}.
REQ-026: The data path SHALL be one instance of the existing mux_8_2_1 (sel, in = din, out = out_bit); the arbiter logic SHALL be local.

Verification
REQ-027: Reset, then req = 8'h01 and out_ready = 1 -> grant = 8'h01 one cycle later, sel = 0, four beats, regrant at cnt 0.
REQ-028: req = 8'h84, out_ready = 1 from reset -> grant 8'h04 for 4 beats, then 8'h80 for 4 beats, then 8'h04 again, with no idle cycle between grants.
REQ-029: Granted at sel = 2 with req = 8'h0C and req[2] dropped after 1 beat -> out_valid low that cycle, then grant = 8'h08 next cycle.
REQ-030: req = 8'h10, out_ready = 0 for 10 cycles, then 1 -> grant held for all 10 cycles, beat_cnt = 0, then 4 beats follow.
REQ-031: din = 8'hA5 while granted to each index 0..7 -> out_bit = 1,0,1,0,0,1,0,1.
REQ-032: rst pulsed for 1 cycle during beat 2 of a grant to sel = 5 -> next cycle grant = 0 and sel = 7; with req = 8'h20 still high, grant = 8'h20 follows one cycle later.
